mux: RTL and testbench

- 2:1 word-wide multiplexer on the datapath. Selects between two operand words under a single control bit.
- Provides a combinational result `out` for same-cycle consumers.
- Also provides a registered copy `out_q`, with a companion `signal_q`, for consumers that need a pipeline-stage-aligned value.
- Sits between operand sources, e.g. register-file read data versus an immediate or ALU result, and downstream datapath logic.

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux.sv | 33 +++
 tb/tb_mux.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared word type and select encodings for the operand multiplexer.
package mux_pkg;

    localparam int MUX_WIDTH = 32;

    typedef logic [MUX_WIDTH-1:0] mux_word_t;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/mux.sv
// 2:1 word multiplexer with a combinational result and a registered, select-aligned copy.
// Latency: out is zero-cycle; out_q/signal_q are one cycle behind.
// Backpressure: none; the selected word is taken and registered every cycle.
module mux
    import mux_pkg::*;
#(
    parameter int               WIDTH       = MUX_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic             signal,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             signal_q
);

    // The conditional operator keeps agreeing bits defined when the select is unknown.
    assign out = (signal == SEL_IN1) ? in_1 : in_0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= RESET_VALUE;
            signal_q <= SEL_IN0;
        end else begin
            out_q    <= out;
            signal_q <= signal;
        end
    end

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux: combinational select, X-select merge, and registered stage.
module tb_mux;
    import mux_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    mux_word_t in_0;
    mux_word_t in_1;
    logic      signal;
    mux_word_t out;
    mux_word_t out_q;
    logic      signal_q;

    typedef struct packed {
        logic      sel;
        mux_word_t dat;
    } exp_t;

    exp_t sb[$];
    exp_t exp_v;
    exp_t last_q;
    int   vectors     = 0;
    int   miscompares = 0;

    mux #(.WIDTH(MUX_WIDTH), .RESET_VALUE('0)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_0     (in_0),
        .in_1     (in_1),
        .signal   (signal),
        .out      (out),
        .out_q    (out_q),
        .signal_q (signal_q)
    );

    always #5 clk = ~clk;

    function automatic mux_word_t model_sel(input logic s, input mux_word_t a, input mux_word_t b);
        return s ? b : a;
    endfunction

    // Drive at the falling edge, check out immediately, queue the value out_q must show next.
    task automatic drive_and_push(input logic s, input mux_word_t a, input mux_word_t b, input string tag);
        @(negedge clk);
        signal = s;
        in_0   = a;
        in_1   = b;
        #1;
        vectors++;
        if (out !== model_sel(s, a, b)) begin
            miscompares++;
            $display("FAIL %s comb out: got %h want %h", tag, out, model_sel(s, a, b));
        end
        vectors++;
        if (rst == 1'b0 && {signal_q, out_q} !== last_q) begin
            miscompares++;
            $display("FAIL %s out_q early: got %b/%h want %b/%h", tag, signal_q, out_q, last_q.sel, last_q.dat);
        end
        sb.push_back('{sel: s, dat: model_sel(s, a, b)});
    endtask

    task automatic test_reset;
        // Load non-reset state, then assert rst between edges.
        @(negedge clk);
        rst    = 1'b0;
        signal = 1'b1;
        in_0   = 32'h7575_7575;
        in_1   = 32'hCDCD_CDCD;
        @(posedge clk);
        #1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_q !== 32'h0) begin
            miscompares++;
            $display("FAIL reset out_q: got %h want 00000000", out_q);
        end
        vectors++;
        if (signal_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset signal_q: got %b want 0", signal_q);
        end
        last_q = '0;
    endtask

    task automatic test_comb;
        logic      s_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        mux_word_t a_tab [4] = '{32'h7575_7575, 32'h7575_7575, 32'h0005_7575, 32'h0000_0000};
        mux_word_t b_tab [4] = '{32'hCDCD_CDCD, 32'hCDCD_CDCD, 32'hCDCD_CDCD, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            signal = s_tab[i];
            in_0   = a_tab[i];
            in_1   = b_tab[i];
            #1;
            vectors++;
            if (out !== model_sel(s_tab[i], a_tab[i], b_tab[i])) begin
                miscompares++;
                $display("FAIL comb[%0d] out: got %h want %h", i, out, model_sel(s_tab[i], a_tab[i], b_tab[i]));
            end
            vectors++;
            if (out_q !== 32'h0) begin
                miscompares++;
                $display("FAIL comb[%0d] out_q held in reset: got %h want 00000000", i, out_q);
            end
        end
    endtask

    task automatic test_xsel;
        signal = 1'bx;
        in_0   = 32'hA5A5_A5A5;
        in_1   = 32'hA5A5_A5A5;
        #1;
        vectors++;
        if (out !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL xsel out: got %h want a5a5a5a5", out);
        end
    endtask

    task automatic test_reg;
        @(negedge clk);
        rst    = 1'b0;
        signal = 1'b1;
        in_0   = 32'h7575_7575;
        in_1   = 32'hCDCD_CDCD;
        sb.push_back('{sel: 1'b1, dat: 32'hCDCD_CDCD});
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        vectors++;
        if (out_q !== exp_v.dat || signal_q !== exp_v.sel) begin
            miscompares++;
            $display("FAIL reg first capture: got %b/%h want %b/%h", signal_q, out_q, exp_v.sel, exp_v.dat);
        end
        last_q = exp_v;
    endtask

    task automatic test_toggle;
        logic seq [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive_and_push(seq[i], 32'h7575_7575, 32'hCDCD_CDCD, "toggle");
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            vectors++;
            if (out_q !== exp_v.dat || signal_q !== exp_v.sel) begin
                miscompares++;
                $display("FAIL toggle[%0d] out_q: got %b/%h want %b/%h", i, signal_q, out_q, exp_v.sel, exp_v.dat);
            end
            last_q = exp_v;
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 30; i++) begin
            drive_and_push(1'($urandom_range(0, 1)), mux_word_t'($urandom), mux_word_t'($urandom), "b2b");
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            vectors++;
            if (out_q !== exp_v.dat || signal_q !== exp_v.sel) begin
                miscompares++;
                $display("FAIL b2b[%0d] out_q: got %b/%h want %b/%h", i, signal_q, out_q, exp_v.sel, exp_v.dat);
            end
            last_q = exp_v;
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        signal = 1'b1;
        in_1   = 32'h1234_5678;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_q !== 32'h0 || signal_q !== 1'b0) begin
            miscompares++;
            $display("FAIL midop reset: got %b/%h want 0/00000000", signal_q, out_q);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_q !== 32'h0 || signal_q !== 1'b0) begin
            miscompares++;
            $display("FAIL midop held: got %b/%h want 0/00000000", signal_q, out_q);
        end
        @(negedge clk);
        rst    = 1'b0;
        signal = 1'b0;
        in_0   = 32'h0BAD_F00D;
        sb.push_back('{sel: 1'b0, dat: 32'h0BAD_F00D});
        @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        vectors++;
        if (out_q !== exp_v.dat || signal_q !== exp_v.sel) begin
            miscompares++;
            $display("FAIL midop release capture: got %b/%h want %b/%h", signal_q, out_q, exp_v.sel, exp_v.dat);
        end
        last_q = exp_v;
    endtask

    initial begin
        last_q = '0;
        test_reset();
        test_comb();
        test_xsel();
        test_reg();
        test_toggle();
        test_back_to_back();
        test_reset_midop();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
